// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: routes one word per cycle into one of four single-entry
// output slots. Each slot drains over its own valid/ready handshake and keeps
// a wrapping count of completed drains.
module demux_1to4_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // producer side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  // slot 0
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CNT_W-1:0] cnt0,
  // slot 1
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt1,
  // slot 2
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt2,
  // slot 3
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]             ready_vec;
  logic [3:0]             valid_vec;
  logic [3:0][WIDTH-1:0]  data_vec;
  logic [3:0][CNT_W-1:0]  cnt_vec;
  logic                   accept;

  assign ready_vec = {out3_ready, out2_ready, out1_ready, out0_ready};

  // A slot can take a word when empty, or when full and draining this cycle.
  // Deliberately independent of in_valid so the producer may wait on it.
  assign in_ready = ~valid_vec[in_sel] | ready_vec[in_sel];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             load;
      logic             drain;

      assign load  = accept & (in_sel == 2'(gi));
      assign drain = valid_q & ready_vec[gi];

      // Next-state: a drain empties the slot, a load (checked last) refills it,
      // so a same-cycle drain+load leaves the slot full with the new word.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (drain) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if (load) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end
      end

      // Slot state registers; reset discards any held word and clears the count.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          cnt_q   <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          cnt_q   <= cnt_d;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign data_vec[gi]  = data_q;
      assign cnt_vec[gi]   = cnt_q;
    end
  endgenerate

  assign out0_valid = valid_vec[0];
  assign out1_valid = valid_vec[1];
  assign out2_valid = valid_vec[2];
  assign out3_valid = valid_vec[3];

  assign out0_data  = data_vec[0];
  assign out1_data  = data_vec[1];
  assign out2_data  = data_vec[2];
  assign out3_data  = data_vec[3];

  assign cnt0       = cnt_vec[0];
  assign cnt1       = cnt_vec[1];
  assign cnt2       = cnt_vec[2];
  assign cnt3       = cnt_vec[3];

endmodule
